// File: rtl/alu_writeback_stage.sv
// Writeback stage behind the 8-bit ALU: one-deep latch, register file, CCR, branch evaluation.
// Optional WB_FORWARD_EN forwards the pending register write onto the read ports.
module alu_writeback_stage #(
  parameter int unsigned NUM_REGS = 4,
  parameter int unsigned CNT_W    = 16,
  localparam int unsigned AW      = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_result,
  input  logic [3:0]       in_nzvc,
  input  logic [2:0]       in_alu_sel,
  input  logic [AW-1:0]    in_dest,
  input  logic             in_wr_en,
  input  logic             hold,
  input  logic [AW-1:0]    rd_addr_a,
  input  logic [AW-1:0]    rd_addr_b,
  output logic [7:0]       rd_data_a,
  output logic [7:0]       rd_data_b,
  output logic [3:0]       ccr,
  output logic             flags_valid,
  input  logic [2:0]       br_cond,
  output logic             br_taken,
  output logic [CNT_W-1:0] commit_count
);

  logic             wb_valid_q, wb_valid_d;
  logic [7:0]       wb_result_q;
  logic [3:0]       wb_nzvc_q;
  logic [2:0]       wb_sel_q;
  logic [AW-1:0]    wb_dest_q;
  logic             wb_wr_en_q;
  logic [7:0]       regs_q [NUM_REGS];
  logic [3:0]       ccr_q, ccr_d;
  logic [CNT_W-1:0] commit_count_q;

  logic accept, commit, wb_writes, dest_ok, reg_we;
  logic [7:0] rf_a, rf_b;

  assign in_ready  = ~wb_valid_q | ~hold;
  assign accept    = in_valid & in_ready;
  assign commit    = wb_valid_q & ~hold;
  // Selects 110/111 never touch the register file.
  assign wb_writes = wb_wr_en_q & (wb_sel_q <= 3'd5);
  assign dest_ok   = 32'(wb_dest_q) < NUM_REGS;
  assign reg_we    = commit & wb_writes & dest_ok;

  always_comb begin
    wb_valid_d = wb_valid_q;
    if (accept) begin
      wb_valid_d = 1'b1;
    end else if (commit) begin
      wb_valid_d = 1'b0;
    end
  end

  always_comb begin
    ccr_d = ccr_q;
    if (commit) begin
      case (wb_sel_q)
        3'b000, 3'b001, 3'b100, 3'b101: ccr_d = wb_nzvc_q;
        3'b010, 3'b011:                 ccr_d = {wb_nzvc_q[3:2], ccr_q[1:0]};
        default:                        ccr_d = ccr_q;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wb_valid_q     <= 1'b0;
      wb_result_q    <= '0;
      wb_nzvc_q      <= '0;
      wb_sel_q       <= '0;
      wb_dest_q      <= '0;
      wb_wr_en_q     <= 1'b0;
      ccr_q          <= '0;
      commit_count_q <= '0;
    end else begin
      wb_valid_q <= wb_valid_d;
      ccr_q      <= ccr_d;
      if (accept) begin
        wb_result_q <= in_result;
        wb_nzvc_q   <= in_nzvc;
        wb_sel_q    <= in_alu_sel;
        wb_dest_q   <= in_dest;
        wb_wr_en_q  <= in_wr_en;
      end
      if (commit) begin
        commit_count_q <= commit_count_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(NUM_REGS); i++) begin
        regs_q[i] <= 8'h00;
      end
    end else if (reg_we) begin
      regs_q[wb_dest_q] <= wb_result_q;
    end
  end

  assign rf_a = (32'(rd_addr_a) < NUM_REGS) ? regs_q[rd_addr_a] : 8'h00;
  assign rf_b = (32'(rd_addr_b) < NUM_REGS) ? regs_q[rd_addr_b] : 8'h00;

`ifdef WB_FORWARD_EN
  logic fwd_live;
  assign fwd_live  = wb_valid_q & wb_writes;
  assign rd_data_a = (fwd_live && (wb_dest_q == rd_addr_a)) ? wb_result_q : rf_a;
  assign rd_data_b = (fwd_live && (wb_dest_q == rd_addr_b)) ? wb_result_q : rf_b;
`else
  assign rd_data_a = rf_a;
  assign rd_data_b = rf_b;
`endif

  // Branch conditions look only at the committed CCR, never at the latch.
  always_comb begin
    br_taken = 1'b0;
    case (br_cond)
      3'b000: br_taken = 1'b1;
      3'b001: br_taken = ccr_q[2];
      3'b010: br_taken = ~ccr_q[2];
      3'b011: br_taken = ccr_q[0];
      3'b100: br_taken = ~ccr_q[0];
      3'b101: br_taken = ccr_q[3];
      3'b110: br_taken = ccr_q[1];
      3'b111: br_taken = ccr_q[3] ^ ccr_q[1];
      default: br_taken = 1'b0;
    endcase
  end

  assign ccr          = ccr_q;
  assign flags_valid  = ~wb_valid_q;
  assign commit_count = commit_count_q;

endmodule

// File: tb/tb_alu_writeback_stage.sv
// Directed bench for alu_writeback_stage: queue-based model compared every cycle, plus literal pins.
module tb_alu_writeback_stage;
  localparam int NR = 4;
  localparam int CW = 4;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          in_valid = 1'b0, in_ready;
  logic [7:0]    in_result = '0;
  logic [3:0]    in_nzvc = '0;
  logic [2:0]    in_alu_sel = '0;
  logic [1:0]    in_dest = '0;
  logic          in_wr_en = 1'b0, hold = 1'b0;
  logic [1:0]    rd_addr_a = '0, rd_addr_b = '0;
  logic [7:0]    rd_data_a, rd_data_b;
  logic [3:0]    ccr;
  logic          flags_valid;
  logic [2:0]    br_cond = '0;
  logic          br_taken;
  logic [CW-1:0] commit_count;

  always #5 clock = ~clock;

  alu_writeback_stage #(.NUM_REGS(NR), .CNT_W(CW)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_result(in_result), .in_nzvc(in_nzvc), .in_alu_sel(in_alu_sel), .in_dest(in_dest),
    .in_wr_en(in_wr_en), .hold(hold), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .rd_data_a(rd_data_a), .rd_data_b(rd_data_b), .ccr(ccr), .flags_valid(flags_valid),
    .br_cond(br_cond), .br_taken(br_taken), .commit_count(commit_count)
  );

  typedef struct {
    logic [7:0] res;
    logic [3:0] nzvc;
    logic [2:0] sel;
    logic [1:0] dest;
    logic       wr;
  } op_t;

  op_t        pend[$];
  logic [7:0] m_regs [NR];
  logic [3:0] m_ccr;
  int         m_count;
  int         checks = 0;
  int         failures = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic exp_ready();
    return (pend.size() == 0) || !hold;
  endfunction

  function automatic logic [7:0] exp_rd(logic [1:0] a);
    logic [7:0] v;
    v = m_regs[a];
`ifdef WB_FORWARD_EN
    if (pend.size() != 0 && pend[0].wr && pend[0].sel < 3'd6 && pend[0].dest == a)
      v = pend[0].res;
`endif
    return v;
  endfunction

  function automatic logic exp_br(logic [2:0] c);
    logic n, z, v, cy;
    {n, z, v, cy} = m_ccr;
    case (c)
      3'd0: return 1'b1;
      3'd1: return z;
      3'd2: return !z;
      3'd3: return cy;
      3'd4: return !cy;
      3'd5: return n;
      3'd6: return v;
      default: return n != v;
    endcase
  endfunction

  task automatic model_reset();
    pend.delete();
    for (int i = 0; i < NR; i++) m_regs[i] = 8'h00;
    m_ccr = 4'b0000;
    m_count = 0;
  endtask

  // Effect of the coming rising edge, from the inputs currently applied.
  task automatic model_edge();
    bit acc, com;
    op_t o;
    acc = in_valid && exp_ready();
    com = (pend.size() != 0) && !hold;
    if (com) begin
      o = pend.pop_front();
      if (o.sel inside {3'd0, 3'd1, 3'd4, 3'd5}) m_ccr = o.nzvc;
      else if (o.sel inside {3'd2, 3'd3}) m_ccr[3:2] = o.nzvc[3:2];
      if (o.wr && o.sel < 3'd6) m_regs[o.dest] = o.res;
      m_count = (m_count + 1) % (1 << CW);
    end
    if (acc) begin
      o.res = in_result; o.nzvc = in_nzvc; o.sel = in_alu_sel; o.dest = in_dest; o.wr = in_wr_en;
      pend.push_back(o);
    end
  endtask

  always @(negedge clock) begin
    chk("in_ready", in_ready, exp_ready());
    chk("flags_valid", flags_valid, pend.size() == 0);
    chk("ccr", ccr, m_ccr);
    chk("commit_count", commit_count, m_count);
    chk("rd_data_a", rd_data_a, exp_rd(rd_addr_a));
    chk("rd_data_b", rd_data_b, exp_rd(rd_addr_b));
    chk("br_taken", br_taken, exp_br(br_cond));
  end

  task automatic cyc(logic v, logic [7:0] r, logic [3:0] f, logic [2:0] s, logic [1:0] d,
                     logic w, logic h);
    @(negedge clock);
    #1;
    in_valid = v; in_result = r; in_nzvc = f; in_alu_sel = s; in_dest = d; in_wr_en = w;
    hold = h;
    br_cond = br_cond + 3'd1;
    rd_addr_a = rd_addr_a + 2'd1;
    rd_addr_b = rd_addr_b + 2'd3;
    model_edge();
  endtask

  task automatic idle();
    cyc(1'b0, 8'h00, 4'h0, 3'd0, 2'd0, 1'b0, 1'b0);
  endtask

  task automatic read_reg(logic [1:0] a, logic [7:0] exp, string name);
    rd_addr_a = a;
    #1;
    chk(name, rd_data_a, exp);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    #1 reset = 1'b1;
    @(negedge clock); #1; reset = 1'b0;

    // Reset with the latch full and a committed write behind it.
    cyc(1'b1, 8'h55, 4'hF, 3'd0, 2'd3, 1'b1, 1'b0);
    cyc(1'b1, 8'hAA, 4'h1, 3'd0, 2'd2, 1'b1, 1'b0);
    cyc(1'b0, 8'h00, 4'h0, 3'd0, 2'd0, 1'b0, 1'b1);
    @(negedge clock); #1;
    reset = 1'b1; in_valid = 1'b0; hold = 1'b0;
    model_reset();
    #1;
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_ccr", ccr, 4'b0000);
    chk("rst_count", commit_count, 0);
    read_reg(2'd3, 8'h00, "rst_r3");
    @(negedge clock); #1; reset = 1'b0;

    // ADD 00 -> R1, flags 0101.
    cyc(1'b1, 8'h00, 4'b0101, 3'd0, 2'd1, 1'b1, 1'b0);
    idle(); idle();
    chk("add_ccr", ccr, 4'b0101);
    br_cond = 3'd1; #1;
    chk("add_br_eq", br_taken, 1'b1);
    chk("add_count", commit_count, 1);
    read_reg(2'd1, 8'h00, "add_r1");

    // SUB sets 0011, then AND keeps V,C.
    cyc(1'b1, 8'h33, 4'b0011, 3'd1, 2'd0, 1'b1, 1'b0);
    cyc(1'b1, 8'h80, 4'b1000, 3'd2, 2'd2, 1'b1, 1'b0);
    idle(); idle();
    chk("and_ccr", ccr, 4'b1011);
    br_cond = 3'd7; #1;
    chk("and_br_lt", br_taken, 1'b0);
    read_reg(2'd2, 8'h80, "and_r2");
    read_reg(2'd0, 8'h33, "sub_r0");

    // Hold with latch full for three cycles, then release.
    cyc(1'b1, 8'h44, 4'b0000, 3'd4, 2'd3, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b1, 8'h66, 4'b1000, 3'd5, 2'd1, 1'b1, 1'b1);
    #1;
    chk("hold_in_ready", in_ready, 1'b0);
    chk("hold_count", commit_count, 3);
    cyc(1'b1, 8'h66, 4'b1000, 3'd5, 2'd1, 1'b1, 1'b0);
    idle(); idle();
    chk("hold_count_after", commit_count, 5);
    chk("hold_ccr", ccr, 4'b1000);
    read_reg(2'd3, 8'h44, "hold_r3");
    read_reg(2'd1, 8'h66, "hold_r1");

    // Back-to-back writes to R2.
    cyc(1'b1, 8'h11, 4'b0000, 3'd0, 2'd2, 1'b1, 1'b0);
    cyc(1'b1, 8'h22, 4'b0110, 3'd0, 2'd2, 1'b1, 1'b0);
    idle();
`ifdef WB_FORWARD_EN
    read_reg(2'd2, 8'h22, "fwd_r2");
`else
    read_reg(2'd2, 8'h11, "nofwd_r2");
`endif
    idle();
    read_reg(2'd2, 8'h22, "b2b_r2");

    // Select 111 counts but changes nothing; then wrap the counter.
    cyc(1'b1, 8'hFF, 4'b1111, 3'd7, 2'd0, 1'b1, 1'b0);
    idle(); idle();
    chk("sel7_count", commit_count, 8);
    chk("sel7_ccr", ccr, 4'b0110);
    read_reg(2'd0, 8'h33, "sel7_r0");
    for (int i = 0; i < 8; i++) cyc(1'b1, 8'(i), 4'hF, 3'd6, 2'(i), 1'b1, 1'b0);
    idle(); idle();
    chk("wrap_count", commit_count, 0);
    chk("wrap_ccr", ccr, 4'b0110);
    read_reg(2'd1, 8'h66, "wrap_r1");

    idle();
    @(negedge clock); #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
